controle_sequencial: RTL and testbench

- Parametrised multi-cycle successor to the processor control sequencer.
- Owns every stall and handshake the datapath needs: input/output button waits, HD read/write with start pulse and timeout, BIOS→memory switch, halt latch, and a programmable time-slice quantum that requests a context save.
- Sits beside the combinational opcode decoder. It drives halt, save, HD handshake, LEDs and op_leitura to the PC/datapath muxes.

---
 rtl/controle_pkg.sv | 39 +++
 rtl/quantum_timer.sv | 46 ++++
 rtl/controle_sequencial.sv | 256 +++++++++++++++++++++++++
 tb/tb_controle_sequencial.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - opcode constants, sequencer state enum and preemption helper
package controle_pkg;

  // Opcodes the sequencer reacts to (low 6 bits of inst_op).
  localparam logic [5:0] OP_IN     = 6'b011111;
  localparam logic [5:0] OP_OUT    = 6'b100000;
  localparam logic [5:0] OP_HD_TAB = 6'b100001;
  localparam logic [5:0] OP_HD_MEM = 6'b100011;
  localparam logic [5:0] OP_HD_ST  = 6'b100100;
  localparam logic [5:0] OP_BIOS   = 6'b100101;
  localparam logic [5:0] OP_HALT   = 6'b111111;

  // hd_op encodings
  localparam logic [1:0] HD_NONE  = 2'd0;
  localparam logic [1:0] HD_READ  = 2'd1;
  localparam logic [1:0] HD_WRITE = 2'd2;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT_IN,
    ST_WAIT_OUT,
    ST_HD_START,
    ST_HD_WAIT,
    ST_SAVE,
    ST_HALTED,
    ST_ERR
  } state_t;

  // Branches, jumps, jal/jalr, set-compares, IN and OUT must not be split
  // from their successor by a context save; everything else may be.
  function automatic logic is_preemptible(input logic [5:0] op);
    logic blocked;
    blocked = (op == 6'b010000) || (op == 6'b010001) ||
              ((op >= 6'b010011) && (op <= 6'b011000)) ||
              (op == OP_IN) || (op == OP_OUT) || (op == 6'b100110);
    return !blocked;
  endfunction

endpackage

// File: rtl/quantum_timer.sv
// rtl/quantum_timer.sv - reloadable time-slice down-counter with expire pulse
//
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   load, load_val    latch a new quantum (also restarts the count)
//   count_en          one tick of eligible execution time
//   expire            combinational pulse on the tick that exhausts the slice
module quantum_timer
  import controle_pkg::*;
#(
  parameter int QW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [QW-1:0] load_val,
  input  logic          count_en,
  output logic          expire
);

  logic [QW-1:0] quantum_q;
  logic [QW-1:0] cnt_q;
  logic          enabled;

  // A zero quantum disables preemption entirely.
  assign enabled = count_en && (quantum_q != '0);

  // Treat an already-empty counter as exhausted so a slice can never stall.
  // A reload in the same cycle takes priority and suppresses the pulse.
  assign expire = !load && enabled && ((cnt_q == '0) || (cnt_q == QW'(1)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      quantum_q <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      quantum_q <= load_val;
      cnt_q     <= load_val;
    end else if (expire) begin
      cnt_q <= quantum_q;
    end else if (enabled) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/controle_sequencial.sv
// rtl/controle_sequencial.sv - multi-cycle control sequencer (stalls, HD handshake, preemption)
//
// Ports:
//   clock, reset            system clock, synchronous active-low reset
//   inst_op                 opcode of the current instruction
//   btn_in, btn_out         raw button levels (rising edge releases a wait)
//   hd_pronto               HD operation complete
//   quantum_load/_val       program the time-slice length (0 = no preemption)
//   preempt_en              global preemption enable
//   halt                    freeze PC / suppress commit
//   save                    one-cycle context-save request
//   reset_pc                pulse on BIOS->memory switch
//   op_leitura              sticky fetch source (0 BIOS, 1 memory)
//   hd_start, hd_op         HD start strobe and operation (1 read, 2 write)
//   led_in/out/mem          wait indicators
//   timeout_err             sticky HD timeout flag
module controle_sequencial
  import controle_pkg::*;
#(
  parameter int OPW        = 6,
  parameter int QW         = 16,
  parameter int TOW        = 20,
  parameter int HD_TIMEOUT = 1000000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] inst_op,
  input  logic           btn_in,
  input  logic           btn_out,
  input  logic           hd_pronto,
  input  logic           quantum_load,
  input  logic [QW-1:0]  quantum_val,
  input  logic           preempt_en,
  output logic           halt,
  output logic           save,
  output logic           reset_pc,
  output logic           op_leitura,
  output logic           hd_start,
  output logic [1:0]     hd_op,
  output logic           led_in,
  output logic           led_out,
  output logic           led_mem,
  output logic           timeout_err
);

  localparam logic [TOW-1:0] TO_LAST = TOW'(HD_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic           btn_in_q, btn_out_q;
  logic           edge_in, edge_out;
  logic           pending_q;
  logic           op_leitura_q;
  logic [1:0]     hd_op_q, hd_op_d;
  logic [TOW-1:0] to_cnt_q;
  logic           to_clr, to_inc, timeout_hit;
  logic           set_bios;
  logic           count_en, expire;
  logic [5:0]     op6;
  logic           op_known;
  logic           preemptible;

  // Opcodes above the 6-bit space are ordinary, preemptible instructions.
  generate
    if (OPW > 6) begin : g_wide_op
      assign op6      = inst_op[5:0];
      assign op_known = ~|inst_op[OPW-1:6];
    end else begin : g_narrow_op
      assign op6      = 6'(inst_op);
      assign op_known = 1'b1;
    end
  endgenerate

  assign preemptible = !op_known || is_preemptible(op6);

  assign edge_in  = btn_in  & ~btn_in_q;
  assign edge_out = btn_out & ~btn_out_q;

  assign timeout_hit = (HD_TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  // Only committed RUN cycles consume the time slice.
  assign count_en = (state_q == ST_RUN) && !halt && preempt_en;

  quantum_timer #(
    .QW(QW)
  ) u_quantum_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (quantum_load),
    .load_val (quantum_val),
    .count_en (count_en),
    .expire   (expire)
  );

  always_comb begin
    state_d     = state_q;
    hd_op_d     = hd_op_q;
    halt        = 1'b0;
    save        = 1'b0;
    reset_pc    = 1'b0;
    hd_start    = 1'b0;
    hd_op       = HD_NONE;
    led_in      = 1'b0;
    led_out     = 1'b0;
    led_mem     = 1'b0;
    timeout_err = 1'b0;
    set_bios    = 1'b0;
    to_clr      = 1'b0;
    to_inc      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (op_known) begin
          case (op6)
            OP_IN: begin
              halt    = 1'b1;
              led_in  = 1'b1;
              state_d = ST_WAIT_IN;
            end
            OP_OUT: begin
              halt    = 1'b1;
              led_out = 1'b1;
              state_d = ST_WAIT_OUT;
            end
            OP_HD_TAB, OP_HD_MEM: begin
              halt    = 1'b1;
              led_mem = 1'b1;
              hd_op_d = HD_READ;
              state_d = ST_HD_START;
            end
            OP_HD_ST: begin
              halt    = 1'b1;
              led_mem = 1'b1;
              hd_op_d = HD_WRITE;
              state_d = ST_HD_START;
            end
            OP_BIOS: begin
              reset_pc = 1'b1;
              set_bios = 1'b1;
            end
            OP_HALT: begin
              halt    = 1'b1;
              state_d = ST_HALTED;
            end
            default: ;
          endcase
        end
        // The current instruction still commits; the save follows it.
        if (!halt && pending_q && preemptible) begin
          state_d = ST_SAVE;
        end
      end

      ST_WAIT_IN: begin
        if (edge_in) begin
          state_d = ST_RUN;
        end else begin
          halt   = 1'b1;
          led_in = 1'b1;
        end
      end

      ST_WAIT_OUT: begin
        if (edge_out) begin
          state_d = ST_RUN;
        end else begin
          halt    = 1'b1;
          led_out = 1'b1;
        end
      end

      ST_HD_START: begin
        halt     = 1'b1;
        hd_start = 1'b1;
        hd_op    = hd_op_q;
        led_mem  = 1'b1;
        to_clr   = 1'b1;
        state_d  = ST_HD_WAIT;
      end

      ST_HD_WAIT: begin
        // Completion beats a coincident timeout.
        if (hd_pronto) begin
          hd_op_d = HD_NONE;
          state_d = ST_RUN;
        end else begin
          halt    = 1'b1;
          led_mem = 1'b1;
          hd_op   = hd_op_q;
          if (timeout_hit) begin
            hd_op_d = HD_NONE;
            state_d = ST_ERR;
          end else begin
            to_inc = 1'b1;
          end
        end
      end

      ST_SAVE: begin
        save    = 1'b1;
        state_d = ST_RUN;
      end

      ST_HALTED: begin
        halt = 1'b1;
      end

      ST_ERR: begin
        halt        = 1'b1;
        timeout_err = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      // Seed edge history with the live level so a held button stays quiet.
      btn_in_q     <= btn_in;
      btn_out_q    <= btn_out;
      pending_q    <= 1'b0;
      op_leitura_q <= 1'b0;
      hd_op_q      <= HD_NONE;
      to_cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      btn_in_q  <= btn_in;
      btn_out_q <= btn_out;
      hd_op_q   <= hd_op_d;

      if (set_bios) begin
        op_leitura_q <= 1'b1;
      end

      if (to_clr) begin
        to_cnt_q <= '0;
      end else if (to_inc) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (!preempt_en) begin
        pending_q <= 1'b0;
      end else if (state_q == ST_SAVE) begin
        pending_q <= 1'b0;
      end else if (expire) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign op_leitura = op_leitura_q;

endmodule

// File: tb/tb_controle_sequencial.sv
// tb/tb_controle_sequencial.sv - directed vector bench for controle_sequencial
module tb_controle_sequencial;

  localparam logic [5:0] IN_OP  = 6'b011111;
  localparam logic [5:0] OUT_OP = 6'b100000;
  localparam logic [5:0] HDM_OP = 6'b100011;
  localparam logic [5:0] HDS_OP = 6'b100100;
  localparam logic [5:0] BIO_OP = 6'b100101;
  localparam logic [5:0] JMP_OP = 6'b010100;
  localparam logic [5:0] ADD_OP = 6'b000000;
  localparam logic [10:0] Z     = 11'b0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  inst_op = '0;
  logic        btn_in = 1'b0, btn_out = 1'b0, hd_pronto = 1'b0;
  logic        quantum_load = 1'b0, preempt_en = 1'b0;
  logic [15:0] quantum_val = 16'd4;
  logic        halt, save, reset_pc, op_leitura, hd_start;
  logic [1:0]  hd_op;
  logic        led_in, led_out, led_mem, timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        bi, bo, hp, ql, pe, chk;
    logic [10:0] ex;
    logic [63:0] tag;
  } vec_t;

  vec_t tbl[$];

  controle_sequencial #(
    .OPW(6), .QW(16), .TOW(20), .HD_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .inst_op(inst_op),
    .btn_in(btn_in), .btn_out(btn_out), .hd_pronto(hd_pronto),
    .quantum_load(quantum_load), .quantum_val(quantum_val), .preempt_en(preempt_en),
    .halt(halt), .save(save), .reset_pc(reset_pc), .op_leitura(op_leitura),
    .hd_start(hd_start), .hd_op(hd_op), .led_in(led_in), .led_out(led_out),
    .led_mem(led_mem), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Expected-output word: {halt,save,reset_pc,op_leitura,hd_start,hd_op,led_in,led_out,led_mem,timeout_err}
  function automatic logic [10:0] e(input logic h, input logic s, input logic rp, input logic ol,
                                    input logic hs, input logic [1:0] ho, input logic li,
                                    input logic lo, input logic lm, input logic te);
    return {h, s, rp, ol, hs, ho, li, lo, lm, te};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic bi, input logic bo,
                              input logic hp, input logic ql, input logic pe, input logic chk,
                              input logic [10:0] ex, input logic [63:0] tag);
    vec_t v;
    v.rst = rst; v.op = op; v.bi = bi; v.bo = bo; v.hp = hp;
    v.ql = ql; v.pe = pe; v.chk = chk; v.ex = ex; v.tag = tag;
    return v;
  endfunction

  // Drive one cycle of inputs after the falling edge, check before the next rise.
  task automatic step(input vec_t v);
    logic [10:0] act;
    @(negedge clock);
    reset = v.rst; inst_op = v.op; btn_in = v.bi; btn_out = v.bo;
    hd_pronto = v.hp; quantum_load = v.ql; preempt_en = v.pe;
    #1;
    if (v.chk) begin
      act = {halt, save, reset_pc, op_leitura, hd_start, hd_op, led_in, led_out, led_mem, timeout_err};
      n_vec++;
      if (act !== v.ex) begin
        n_bad++;
        $display("FAIL %0s (vector %0d): got %b want %b", v.tag, n_vec, act, v.ex);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle
    tbl.push_back(mk(0, ADD_OP, 0, 0, 0, 0, 0, 0, Z, "rst"));
    tbl.push_back(mk(0, ADD_OP, 0, 0, 0, 0, 0, 1, Z, "rst"));
    tbl.push_back(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, Z, "idle"));
    // IN wait: 5 halted cycles, stray btn_out edge ignored, commit on btn_in edge
    tbl.push_back(mk(1, IN_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,1,0,0,0), "in_run"));
    tbl.push_back(mk(1, IN_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,1,0,0,0), "in_wait"));
    tbl.push_back(mk(1, IN_OP, 0, 1, 0, 0, 0, 1, e(1,0,0,0,0,0,1,0,0,0), "in_bout"));
    tbl.push_back(mk(1, IN_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,1,0,0,0), "in_wait"));
    tbl.push_back(mk(1, IN_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,1,0,0,0), "in_wait"));
    tbl.push_back(mk(1, IN_OP, 1, 0, 0, 0, 0, 1, Z, "in_edge"));
    tbl.push_back(mk(1, ADD_OP, 1, 0, 0, 0, 0, 1, Z, "in_done"));
    tbl.push_back(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, Z, "in_done"));
    // OUT wait, btn_in edge ignored
    tbl.push_back(mk(1, OUT_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,0,1,0,0), "out_run"));
    tbl.push_back(mk(1, OUT_OP, 1, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,0,1,0,0), "out_bin"));
    tbl.push_back(mk(1, OUT_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,0,1,0,0), "out_wait"));
    tbl.push_back(mk(1, OUT_OP, 0, 1, 0, 0, 0, 1, Z, "out_edge"));
    tbl.push_back(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, Z, "out_done"));
    // HD write, hd_pronto at cycle 7
    tbl.push_back(mk(1, HDS_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,0,0,1,0), "hd_run"));
    tbl.push_back(mk(1, HDS_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,1,2,0,0,1,0), "hd_start"));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, HDS_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,2,0,0,1,0), "hd_wait"));
    tbl.push_back(mk(1, HDS_OP, 0, 0, 1, 0, 0, 1, Z, "hd_done"));
    tbl.push_back(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, Z, "hd_idle"));
    // BIOS switch
    tbl.push_back(mk(1, BIO_OP, 0, 0, 0, 0, 0, 1, e(0,0,1,0,0,0,0,0,0,0), "bios"));
    tbl.push_back(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, e(0,0,0,1,0,0,0,0,0,0), "bios_ol"));
    tbl.push_back(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, e(0,0,0,1,0,0,0,0,0,0), "bios_ol"));

    foreach (tbl[i]) step(tbl[i]);

    // HD timeout (HD_TIMEOUT=8): ERR after 8 HD_WAIT cycles, held until reset
    step(mk(1, HDM_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,1,0,0,0,0,1,0), "to_run"));
    step(mk(1, HDM_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,1,1,1,0,0,1,0), "to_start"));
    for (int k = 0; k < 8; k++)
      step(mk(1, HDM_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,1,0,1,0,0,1,0), "to_wait"));
    step(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,1,0,0,0,0,0,1), "to_err"));
    step(mk(1, ADD_OP, 0, 0, 1, 0, 0, 1, e(1,0,0,1,0,0,0,0,0,1), "to_errhp"));
    step(mk(0, ADD_OP, 0, 0, 0, 0, 0, 0, Z, "to_rst"));
    step(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, Z, "to_clear"));

    // Quantum 4 on an add stream: save every 5th cycle
    step(mk(1, ADD_OP, 0, 0, 0, 1, 1, 1, Z, "q_load"));
    for (int k = 0; k < 16; k++)
      step(mk(1, ADD_OP, 0, 0, 0, 0, 1, 1,
              (k == 5 || k == 10 || k == 15) ? e(0,1,0,0,0,0,0,0,0,0) : Z, "q_add"));

    // Expiry while jumps execute: save deferred to the next add
    step(mk(1, ADD_OP, 0, 0, 0, 1, 0, 1, Z, "d_load"));
    for (int k = 0; k < 4; k++)
      step(mk(1, ADD_OP, 0, 0, 0, 0, 1, 1, Z, "d_count"));
    step(mk(1, JMP_OP, 0, 0, 0, 0, 1, 1, Z, "d_jmp"));
    step(mk(1, JMP_OP, 0, 0, 0, 0, 1, 1, Z, "d_jmp"));
    step(mk(1, ADD_OP, 0, 0, 0, 0, 1, 1, Z, "d_add"));
    step(mk(1, ADD_OP, 0, 0, 0, 0, 1, 1, e(0,1,0,0,0,0,0,0,0,0), "d_save"));
    step(mk(1, ADD_OP, 0, 0, 0, 0, 1, 1, Z, "d_after"));

    // Reset in HD_WAIT with btn_in held high: no restart, no spurious edge
    step(mk(1, HDM_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,0,0,1,0), "r_run"));
    step(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,1,1,0,0,1,0), "r_start"));
    step(mk(1, ADD_OP, 1, 0, 0, 0, 0, 1, e(1,0,0,0,0,1,0,0,1,0), "r_wait"));
    step(mk(0, ADD_OP, 1, 0, 0, 0, 0, 0, Z, "r_rst"));
    step(mk(0, ADD_OP, 1, 0, 0, 0, 0, 1, Z, "r_rst"));
    step(mk(1, IN_OP, 1, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,1,0,0,0), "r_in"));
    step(mk(1, IN_OP, 1, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,1,0,0,0), "r_held"));
    step(mk(1, IN_OP, 0, 0, 0, 0, 0, 1, e(1,0,0,0,0,0,1,0,0,0), "r_low"));
    step(mk(1, IN_OP, 1, 0, 0, 0, 0, 1, Z, "r_edge"));
    step(mk(1, ADD_OP, 0, 0, 0, 0, 0, 1, Z, "r_done"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
